// File: rtl/ysyx_22051145_mdu_pkg.sv
// ysyx_22051145_mdu_pkg: shared XLEN, MDU op encodings (MDU_OP_*), FSM states and the op result selector
package ysyx_22051145_mdu_pkg;
  localparam int MDU_XLEN = 64;
  typedef enum logic [3:0] {
    MDU_OP_MUL    = 4'd0,
    MDU_OP_MULH   = 4'd1,
    MDU_OP_MULHSU = 4'd2,
    MDU_OP_MULHU  = 4'd3,
    MDU_OP_DIV    = 4'd4,
    MDU_OP_DIVU   = 4'd5,
    MDU_OP_REM    = 4'd6,
    MDU_OP_REMU   = 4'd7,
    MDU_OP_MULW   = 4'd8,
    MDU_OP_DIVW   = 4'd9,
    MDU_OP_DIVUW  = 4'd10,
    MDU_OP_REMW   = 4'd11,
    MDU_OP_REMUW  = 4'd12
  } mdu_op_e;
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ITER, S_POST, S_DONE} mdu_state_e;
  function automatic logic is_w(input logic [3:0] op);
    return op inside {MDU_OP_MULW, MDU_OP_DIVW, MDU_OP_DIVUW, MDU_OP_REMW, MDU_OP_REMUW};
  endfunction
  function automatic logic is_div(input logic [3:0] op);
    return op inside {MDU_OP_DIV, MDU_OP_DIVU, MDU_OP_REM, MDU_OP_REMU,
                      MDU_OP_DIVW, MDU_OP_DIVUW, MDU_OP_REMW, MDU_OP_REMUW};
  endfunction
  function automatic logic [MDU_XLEN-1:0] mdu_sel(input logic [3:0] op, input logic [2*MDU_XLEN-1:0] p,
                                                  input logic [MDU_XLEN-1:0] q, input logic [MDU_XLEN-1:0] r);
    logic [MDU_XLEN-1:0] v;
    v = op inside {MDU_OP_MUL, MDU_OP_MULW} ? p[MDU_XLEN-1:0] :
        op inside {MDU_OP_MULH, MDU_OP_MULHSU, MDU_OP_MULHU} ? p[2*MDU_XLEN-1:MDU_XLEN] :
        op inside {MDU_OP_DIV, MDU_OP_DIVU, MDU_OP_DIVW, MDU_OP_DIVUW} ? q :
        op inside {MDU_OP_REM, MDU_OP_REMU, MDU_OP_REMW, MDU_OP_REMUW} ? r : '0;
    return is_w(op) ? {{(MDU_XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction
endpackage

// File: rtl/ysyx_22051145_mdu_core.sv
// ysyx_22051145_mdu_core: shift-add / restoring-divide engine (load, step strobes; a,b magnitudes and count n in; last, prod, quot, rem out)
module ysyx_22051145_mdu_core
  import ysyx_22051145_mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              div,
  input  logic              r4,
  input  logic              w,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic [6:0]        n,
  output logic              last,
  output logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   quot,
  output logic [XLEN-1:0]   rem
);
  logic [2*XLEN-1:0] acc, y, addend;
  logic [XLEN-1:0] x;
  logic [6:0] cnt;
  logic [XLEN:0] rs;
  logic [XLEN+1:0] diff;
  always_comb begin
    addend = (x[0] ? y : '0) + (r4 && x[1] ? y << 1 : '0);
    rs = {acc[XLEN-1:0], x[XLEN-1]};
    diff = {1'b0, rs} - {2'b0, y[XLEN-1:0]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      y <= '0;
      x <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= '0;
      y <= {{XLEN{1'b0}}, b};
      x <= div && w ? a << 32 : a;
      cnt <= n;
    end else if (step) begin
      cnt <= cnt - 1'b1;
      if (div) begin
        acc <= {{(XLEN-1){1'b0}}, diff[XLEN+1] ? rs : diff[XLEN:0]};
        x <= {x[XLEN-2:0], ~diff[XLEN+1]};
      end else begin
        acc <= acc + addend;
        y <= r4 ? y << 2 : y << 1;
        x <= r4 ? x >> 2 : x >> 1;
      end
    end
  end
  assign last = cnt == 7'd1;
  assign prod = acc;
  assign quot = x;
  assign rem = acc[XLEN-1:0];
endmodule

// File: rtl/ysyx_22051145_mdu_ctrl.sv
// ysyx_22051145_mdu_ctrl: RV64M sequencer (in_valid/in_ready/in_op/in_src1/in_src2 -> out_valid/out_ready/out_result, flush, busy); YSYX_22051145_MUL_RADIX4_EN enables radix-4 multiply
module ysyx_22051145_mdu_ctrl
  import ysyx_22051145_mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);
`ifdef YSYX_22051145_MUL_RADIX4_EN
  localparam logic R4 = 1'b1;
`else
  localparam logic R4 = 1'b0;
`endif
  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, 31'b0};
  mdu_state_e state, nxt;
  logic [3:0] op;
  logic [XLEN-1:0] src1, src2, a_ext, b_ext, a_mag, b_mag, spec_q, spec_r, quot, rem, q_fix, r_fix;
  logic [2*XLEN-1:0] prod, p_fix;
  logic w, dv, rsv, sa, sb, zx, na, nb, dz, ov, special, neg, neg_a, last;
  logic [6:0] n;
  always_comb begin
    w = is_w(op);
    dv = is_div(op);
    rsv = op > 4'd12;
    sa = op inside {MDU_OP_MULH, MDU_OP_MULHSU, MDU_OP_DIV, MDU_OP_REM, MDU_OP_MULW, MDU_OP_DIVW, MDU_OP_REMW};
    sb = op inside {MDU_OP_MULH, MDU_OP_DIV, MDU_OP_REM, MDU_OP_MULW, MDU_OP_DIVW, MDU_OP_REMW};
    zx = op inside {MDU_OP_DIVUW, MDU_OP_REMUW};
    a_ext = !w ? src1 : zx ? {{(XLEN-32){1'b0}}, src1[31:0]} : {{(XLEN-32){src1[31]}}, src1[31:0]};
    b_ext = !w ? src2 : zx ? {{(XLEN-32){1'b0}}, src2[31:0]} : {{(XLEN-32){src2[31]}}, src2[31:0]};
    na = sa && a_ext[XLEN-1];
    nb = sb && b_ext[XLEN-1];
    a_mag = na ? -a_ext : a_ext;
    b_mag = nb ? -b_ext : b_ext;
    dz = dv && b_ext == '0;
    ov = dv && sa && &b_ext && a_ext == (w ? MIN_W : MIN_D);
    special = dz || ov || rsv;
    spec_q = dz ? '1 : a_ext;
    spec_r = dz ? a_ext : '0;
    n = (w ? 7'd32 : 7'd64) >> (R4 && !dv);
    p_fix = neg ? -prod : prod;
    q_fix = neg ? -quot : quot;
    r_fix = neg_a ? -rem : rem;
    nxt = flush ? S_IDLE :
          state == S_IDLE ? (in_valid ? S_PRE : S_IDLE) :
          state == S_PRE ? (special ? S_DONE : S_ITER) :
          state == S_ITER ? (last ? S_POST : S_ITER) :
          state == S_POST ? S_DONE :
          out_ready ? S_IDLE : S_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
      op <= '0;
      src1 <= '0;
      src2 <= '0;
      neg <= 1'b0;
      neg_a <= 1'b0;
      out_result <= '0;
    end else begin
      state <= nxt;
      in_ready <= nxt == S_IDLE;
      out_valid <= nxt == S_DONE;
      busy <= nxt != S_IDLE;
      if (state == S_IDLE && in_valid) begin
        op <= in_op;
        src1 <= in_src1;
        src2 <= in_src2;
      end
      if (state == S_PRE) begin
        neg <= na ^ nb;
        neg_a <= na;
        if (special) out_result <= mdu_sel(op, '0, spec_q, spec_r);
      end
      if (state == S_POST) out_result <= mdu_sel(op, p_fix, q_fix, r_fix);
    end
  end
  ysyx_22051145_mdu_core #(.XLEN(XLEN)) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (state == S_PRE && !special),
    .step (state == S_ITER),
    .div  (dv),
    .r4   (R4),
    .w    (w),
    .a    (a_mag),
    .b    (b_mag),
    .n    (n),
    .last (last),
    .prod (prod),
    .quot (quot),
    .rem  (rem)
  );
endmodule

// File: tb/tb_ysyx_22051145_mdu_ctrl.sv
// tb_ysyx_22051145_mdu_ctrl: random and directed checks of the MDU sequencer against an arithmetic RV64M model
module tb_ysyx_22051145_mdu_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [3:0] in_op = '0;
  logic [63:0] in_src1 = '0;
  logic [63:0] in_src2 = '0;
  logic in_ready, out_valid, busy;
  logic [63:0] out_result;
  int n_cmp = 0;
  int n_bad = 0;
  localparam logic [63:0] MN = 64'h8000_0000_0000_0000;
`ifdef YSYX_22051145_MUL_RADIX4_EN
  localparam int MDIV = 2;
`else
  localparam int MDIV = 1;
`endif
  always #5 clk = ~clk;
  ysyx_22051145_mdu_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction
  function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] pp;
    logic [63:0] r;
    logic [31:0] ua, ub;
    longint sa, sb, sq;
    int wa, wb, iq;
    sa = a;
    sb = b;
    ua = a[31:0];
    ub = b[31:0];
    wa = ua;
    wb = ub;
    r = '0;
    case (op)
      4'd0: r = a * b;
      4'd1: begin pp = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = pp[127:64]; end
      4'd2: begin pp = {{64{a[63]}}, a} * {64'd0, b}; r = pp[127:64]; end
      4'd3: begin pp = {64'd0, a} * {64'd0, b}; r = pp[127:64]; end
      4'd4: if (b == 0) r = '1; else if (a == MN && b == '1) r = a; else begin sq = sa / sb; r = sq; end
      4'd5: r = b == 0 ? '1 : a / b;
      4'd6: if (b == 0) r = a; else if (a == MN && b == '1) r = '0; else begin sq = sa % sb; r = sq; end
      4'd7: r = b == 0 ? a : a % b;
      4'd8: r = sx32(ua * ub);
      4'd9: if (ub == 0) r = '1; else if (ua == 32'h8000_0000 && ub == '1) r = sx32(ua); else begin iq = wa / wb; r = sx32(iq); end
      4'd10: r = ub == 0 ? '1 : sx32(ua / ub);
      4'd11: if (ub == 0) r = sx32(ua); else if (ua == 32'h8000_0000 && ub == '1) r = '0; else begin iq = wa % wb; r = sx32(iq); end
      4'd12: r = ub == 0 ? sx32(ua) : sx32(ua % ub);
      default: r = '0;
    endcase
    return r;
  endfunction
  function automatic int ref_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    bit w, dv, sg, zero, ovf;
    if (op > 12) return 2;
    w = op >= 8;
    dv = (op >= 4 && op <= 7) || op >= 9;
    if (!dv) return (w ? 32 : 64) / MDIV + 3;
    sg = op == 4 || op == 6 || op == 9 || op == 11;
    zero = w ? b[31:0] == 0 : b == 0;
    ovf = sg && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) : (a == MN && b == '1));
    return (zero || ovf) ? 2 : (w ? 32 : 64) + 3;
  endfunction
  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input int hold, input bit early);
    logic [63:0] exp;
    int want, cyc;
    exp = ref_res(op, a, b);
    want = ref_lat(op, a, b);
    chk("idle_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_op = op;
    in_src1 = a;
    in_src2 = b;
    out_ready = early;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op = 4'($urandom);
    in_src1 = {$urandom, $urandom};
    in_src2 = {$urandom, $urandom};
    cyc = 1;
    chk("busy_pre", 64'(busy), 64'd1);
    chk("ready_pre", 64'(in_ready), 64'd0);
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk($sformatf("latency op%0d", op), 64'(cyc), 64'(want));
    chk($sformatf("result op%0d a=%h b=%h", op, a, b), out_result, exp);
    if (!early) begin
      repeat (hold) begin
        @(posedge clk);
        #1;
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_result", out_result, exp);
        chk("hold_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("after_valid", 64'(out_valid), 64'd0);
    chk("after_busy", 64'(busy), 64'd0);
  endtask
  initial begin
    int cyc;
    bit seen;
    logic [3:0] op;
    logic [63:0] a, b;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    run_op(4'd2, '1, 64'd2, 0, 1'b0);
    run_op(4'd4, -64'sd7, 64'd2, 1, 1'b0);
    run_op(4'd6, -64'sd7, 64'd2, 0, 1'b1);
    run_op(4'd5, 64'h1234, 64'd0, 0, 1'b0);
    run_op(4'd7, 64'h1234, 64'd0, 0, 1'b1);
    run_op(4'd9, 64'h0000_0000_8000_0000, '1, 0, 1'b0);
    run_op(4'd11, 64'h0000_0000_8000_0000, '1, 0, 1'b0);
    run_op(4'd4, MN, '1, 0, 1'b0);
    run_op(4'd14, 64'd5, 64'd6, 0, 1'b0);
    run_op(4'd8, 64'h7FFF_FFFF, 64'd2, 5, 1'b0);
    in_valid = 1'b1;
    in_op = 4'd4;
    in_src1 = 64'd1000;
    in_src2 = 64'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 1;
    seen = 1'b0;
    while (cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      seen |= out_valid;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_ready", 64'(in_ready), 64'd1);
    chk("flush_valid", 64'(out_valid | seen), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    run_op(4'd0, 64'd3, 64'd4, 0, 1'b0);
    flush = 1'b1;
    in_valid = 1'b1;
    in_op = 4'd0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_accept_busy", 64'(busy), 64'd0);
    chk("flush_accept_ready", 64'(in_ready), 64'd1);
    run_op(4'd1, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_0000_1234_5678, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst2_result", out_result, 64'd0);
    chk("rst2_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_op = 4'd5;
    in_src1 = 64'd99;
    in_src2 = 64'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = MN; b = '1; end
        2: begin a = {$urandom, 32'h8000_0000}; b = {$urandom, 32'hFFFF_FFFF}; end
        3: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 20)); end
        4: b = {32'd0, $urandom} & 64'hFFFF_FFFF_0000_0000;
        default: ;
      endcase
      run_op(op, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
